// File: rtl/wb_burst_master.sv
// Wishbone burst master for SDRAM bring-up: writes seed+k patterns or reads them
// back and counts mismatches, with an ack watchdog that aborts stalled bursts.
module wb_burst_master #(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int LEN_W  = 8,
  parameter int TO_CYC = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              sdr_init_done_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [APP_AW-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [dw-1:0]     cmd_seed_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  input  logic              err_clr_i,
  output logic [15:0]       err_cnt_o,
  output logic [APP_AW-1:0] first_err_addr_o
);

  localparam int AL = (dw / 8 > 1) ? $clog2(dw / 8) : 0;
  localparam int BW = LEN_W + 1;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [APP_AW-1:0] ALIGN_MASK = ~(APP_AW'((64'd1 << AL) - 64'd1));
  localparam logic [APP_AW-1:0] STEP       = APP_AW'(dw / 8);
  localparam logic [TW-1:0]     TO_LAST    = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {WAIT_INIT, IDLE, BURST, DONE} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, init_s;
  logic              we_q, we_d;
  logic [APP_AW-1:0] addr_q, addr_d;
  logic [BW-1:0]     beats_q, beats_d;
  logic [BW-1:0]     k_q, k_d;
  logic [dw-1:0]     seed_q, seed_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [APP_AW-1:0] first_err_q, first_err_d;

  logic [dw-1:0] pattern;
  logic          last_beat, in_burst, mismatch;

  assign init_s    = sync2_q;
  assign in_burst  = (state_q == BURST);
  assign pattern   = seed_q + dw'(k_q);
  assign last_beat = (k_q == beats_q - 1'b1);
  assign mismatch  = in_burst && wb_ack_i && !we_q && (wb_dat_i != pattern);

  // Two-flop synchronizer for the SDRAM controller's init flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sdr_init_done_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= WAIT_INIT;
      we_q        <= 1'b0;
      addr_q      <= '0;
      beats_q     <= '0;
      k_q         <= '0;
      seed_q      <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      k_q         <= k_d;
      seed_q      <= seed_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    k_d         = k_q;
    seed_d      = seed_q;
    to_cnt_d    = to_cnt_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    unique case (state_q)
      WAIT_INIT: if (init_s) state_d = IDLE;
      IDLE: begin
        if (cmd_valid_i) begin
          state_d  = BURST;
          we_d     = cmd_we_i;
          addr_d   = cmd_addr_i & ALIGN_MASK;
          beats_d  = BW'(cmd_len_i) + BW'(1);
          k_d      = '0;
          seed_d   = cmd_seed_i;
          to_cnt_d = '0;
        end
      end
      BURST: begin
        if (wb_ack_i) begin
          to_cnt_d = '0;
          addr_d   = addr_q + STEP;
          k_d      = k_q + 1'b1;
          if (last_beat) state_d = DONE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = WAIT_INIT;
    endcase

    // Error count of zero means capture is armed; only a clear can return it to zero.
    if (mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0)    first_err_d = addr_q;
    end

    if (err_clr_i) begin
      err_cnt_d   = '0;
      first_err_d = '0;
      timeout_d   = 1'b0;
    end
  end

  assign cmd_ready_o      = (state_q == IDLE);
  assign busy_o           = in_burst || (state_q == DONE);
  assign done_o           = (state_q == DONE);
  assign timeout_o        = timeout_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;

  assign wb_cyc_o  = in_burst;
  assign wb_stb_o  = in_burst;
  assign wb_we_o   = in_burst && we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o  = (in_burst && we_q) ? pattern : '0;
  assign wb_sel_o  = in_burst ? '1 : '0;

  always_comb begin
    wb_cti_o = 3'b000;
    if (in_burst && beats_q != BW'(1)) wb_cti_o = last_beat ? 3'b111 : 3'b010;
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: init gating, write/read bursts, error
// capture, ack timeout, address wrap and asynchronous reset mid-burst.
module tb_wb_burst_master;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          init;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_seed;
  logic          cyc, stb, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] dat_o;
  logic [DW/8-1:0] sel;
  logic [2:0]    cti;
  logic          ack;
  logic [DW-1:0] dat_i;
  logic          busy, done, tmo, err_clr;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wb_burst_master #(.APP_AW(AW), .dw(DW), .LEN_W(LW), .TO_CYC(1024)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .sdr_init_done_i(init),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_seed_i(cmd_seed),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr),
    .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_cti_o(cti),
    .wb_ack_i(ack), .wb_dat_i(dat_i),
    .busy_o(busy), .done_o(done), .timeout_o(tmo), .err_clr_i(err_clr),
    .err_cnt_o(err_cnt), .first_err_addr_o(first_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".cyc"}, 64'(cyc), 0);
    chk({tag, ".stb"}, 64'(stb), 0);
    chk({tag, ".we"}, 64'(we), 0);
    chk({tag, ".addr"}, 64'(addr), 0);
    chk({tag, ".dat"}, 64'(dat_o), 0);
    chk({tag, ".sel"}, 64'(sel), 0);
    chk({tag, ".cti"}, 64'(cti), 0);
    chk({tag, ".ready"}, 64'(cmd_ready), 0);
    chk({tag, ".busy"}, 64'(busy), 0);
    chk({tag, ".done"}, 64'(done), 0);
    chk({tag, ".tmo"}, 64'(tmo), 0);
    chk({tag, ".errcnt"}, 64'(err_cnt), 0);
    chk({tag, ".firsterr"}, 64'(first_err), 0);
  endtask

  // Wait (bounded) for ready, present the command, and let the accept edge pass.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input logic [DW-1:0] s);
    int n = 0;
    cmd_we = w; cmd_addr = a; cmd_len = l; cmd_seed = s; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    chk("issue.ready", 64'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    chk("issue.cyc", 64'(cyc), 1);
  endtask

  task automatic beat(input string tag, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input logic [2:0] ec, input logic [DW-1:0] rd);
    chk({tag, ".stb"}, 64'(stb), 1);
    chk({tag, ".addr"}, 64'(ea), 64'(addr));
    chk({tag, ".dat"}, 64'(dat_o), 64'(ed));
    chk({tag, ".cti"}, 64'(cti), 64'(ec));
    ack = 1'b1; dat_i = rd;
    tick();
    ack = 1'b0; dat_i = '0;
  endtask

  task automatic finish_burst(input string tag);
    chk({tag, ".cyc_drop"}, 64'(cyc), 0);
    chk({tag, ".done"}, 64'(done), 1);
    chk({tag, ".busy"}, 64'(busy), 1);
    tick();
    chk({tag, ".done_clr"}, 64'(done), 0);
    chk({tag, ".idle"}, 64'(cmd_ready), 1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; init = 1'b0; cmd_valid = 1'b1; cmd_we = 1'b1;
    cmd_addr = 26'h100; cmd_len = 8'd3; cmd_seed = 32'hA000_0000;
    ack = 1'b0; dat_i = '0; err_clr = 1'b0;
    #1;
    chk_reset_outputs("reset");
    tick(); tick();
    rst = 1'b0;

    // Init held low: a pending command must never be accepted.
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("wait_init.ready", 64'(cmd_ready), 0);
    end
    init = 1'b1;
    tick(); chk("sync1.ready", 64'(cmd_ready), 0);
    tick(); chk("sync2.ready", 64'(cmd_ready), 0);
    tick(); chk("idle.ready", 64'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;

    // Write burst at 0x100, four beats.
    chk("wr.we", 64'(we), 1);
    chk("wr.sel", 64'(sel), 64'hF);
    chk("wr.busy", 64'(busy), 1);
    beat("wr0", 26'h100, 32'hA000_0000, 3'b010, 0);
    beat("wr1", 26'h104, 32'hA000_0001, 3'b010, 0);
    beat("wr2", 26'h108, 32'hA000_0002, 3'b010, 0);
    beat("wr3", 26'h10C, 32'hA000_0003, 3'b111, 0);
    finish_burst("wr");

    // Stray ack while idle must not touch anything.
    ack = 1'b1; dat_i = 32'h1234_5678;
    tick();
    ack = 1'b0;
    chk("stray.errcnt", 64'(err_cnt), 0);
    chk("stray.cyc", 64'(cyc), 0);

    // Read-check burst with one corrupted beat.
    issue(1'b0, 26'h100, 8'd3, 32'hA000_0000);
    chk("rd.we", 64'(we), 0);
    beat("rd0", 26'h100, 0, 3'b010, 32'hA000_0000);
    beat("rd1", 26'h104, 0, 3'b010, 32'hA000_0001);
    beat("rd2", 26'h108, 0, 3'b010, 32'hDEAD_BEEF);
    beat("rd3", 26'h10C, 0, 3'b111, 32'hA000_0003);
    chk("rd.errcnt", 64'(err_cnt), 1);
    chk("rd.firsterr", 64'(first_err), 64'h108);
    finish_burst("rd");

    // Second error, single beat: count goes up, first address is kept.
    issue(1'b0, 26'h200, 8'd0, 32'h5);
    beat("rd1b", 26'h200, 0, 3'b000, 32'h6);
    chk("rd2.errcnt", 64'(err_cnt), 2);
    chk("rd2.firsterr", 64'(first_err), 64'h108);
    finish_burst("rd2");

    // No ack at all: watchdog aborts after 1024 strobe cycles.
    issue(1'b0, 26'h300, 8'd0, 32'h0);
    cnt = 0;
    while (cyc && cnt < 1100) begin cnt++; tick(); end
    chk("tmo.stb_cycles", 64'(cnt), 1024);
    chk("tmo.done", 64'(done), 1);
    chk("tmo.sticky", 64'(tmo), 1);
    tick();
    chk("tmo.held", 64'(tmo), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr.tmo", 64'(tmo), 0);
    chk("clr.errcnt", 64'(err_cnt), 0);
    chk("clr.firsterr", 64'(first_err), 0);

    // Address wraps at the top of the byte address space.
    issue(1'b1, 26'h3FF_FFFC, 8'd1, 32'h11);
    beat("wrap0", 26'h3FF_FFFC, 32'h11, 3'b010, 0);
    beat("wrap1", 26'h000_0000, 32'h12, 3'b111, 0);
    finish_burst("wrap");

    // Unaligned start is forced to a beat boundary; reset lands on beat 1.
    issue(1'b1, 26'h203, 8'd2, 32'h7);
    beat("rst0", 26'h200, 32'h7, 3'b010, 0);
    chk("rst.beat1_addr", 64'(addr), 64'h204);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    #1 rst = 1'b0;
    tick(); chk("post_rst.sync1", 64'(cmd_ready), 0);
    chk("post_rst.nocyc", 64'(cyc), 0);
    tick(); chk("post_rst.sync2", 64'(cmd_ready), 0);
    tick(); chk("post_rst.idle", 64'(cmd_ready), 1);
    chk("post_rst.noreplay", 64'(cyc), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter APP_AW, default 26, Wishbone byte address width.
REQ-002 SHALL have parameter dw, default 32, Wishbone data width; dw/8 bytes per beat.
REQ-003 SHALL have parameter LEN_W, default 8, burst length field width.
REQ-004 SHALL have parameter TO_CYC, default 1024, ack timeout in clocks.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  async active-high reset.
REQ-006 SHALL have port sdr_init_done_i  in  1  SDRAM init complete (asynchronous to wb_clk_i).
REQ-007 SHALL have ports cmd_valid_i  in  1  command valid; cmd_ready_o  out  1  command accepted.
REQ-008 SHALL have ports cmd_we_i  in  1  1=write burst, 0=read-and-check burst; cmd_addr_i  in  APP_AW  start byte address; cmd_len_i  in  LEN_W  beats minus one; cmd_seed_i  in  dw  pattern seed.
REQ-009 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o  out  1; wb_addr_o  out  APP_AW; wb_dat_o  out  dw; wb_sel_o  out  dw/8; wb_cti_o  out  3.
REQ-010 SHALL have ports wb_ack_i  in  1; wb_dat_i  in  dw.
REQ-011 SHALL have ports busy_o  out  1; done_o  out  1 one-cycle pulse; timeout_o  out  1 sticky; err_clr_i  in  1; err_cnt_o  out  16; first_err_addr_o  out  APP_AW.

Function
REQ-012 SHALL synchronize sdr_init_done_i through two flops; the synced value is init_s.
REQ-013 SHALL implement FSM states WAIT_INIT, IDLE, BURST, DONE; reset state WAIT_INIT.
REQ-014 SHALL move WAIT_INIT->IDLE when init_s=1; no command is accepted in WAIT_INIT.
REQ-015 SHALL drive cmd_ready_o=1 only in IDLE; a command is accepted on cmd_valid_i & cmd_ready_o and the state moves to BURST next cycle.
REQ-016 SHALL latch on accept: we, addr with low log2(dw/8) bits forced to 0, beat count = cmd_len_i+1, and seed.
REQ-017 SHALL in BURST hold wb_cyc_o=wb_stb_o=1, wb_we_o=latched we, wb_sel_o=all ones until the last ack.
REQ-018 SHALL drive wb_dat_o = seed + k (mod 2^dw) for beat k, k starting at 0; wb_dat_o = 0 when not writing.
REQ-019 SHALL, per ack, advance wb_addr_o by dw/8 (wrapping mod 2^APP_AW) and increment k in the same cycle.
REQ-020 SHALL drive wb_cti_o = 3'b000 for a single-beat burst, 3'b010 for non-final beats, 3'b111 on the final beat, and 3'b000 outside BURST.
REQ-021 SHALL, on read beats, compare wb_dat_i with seed + k at ack; on mismatch, increment err_cnt_o, saturating at 16'hFFFF.
REQ-022 SHALL capture first_err_addr_o on the first mismatch since reset or err_clr_i; later mismatches leave it unchanged.
REQ-023 SHALL make err_clr_i zero err_cnt_o and first_err_addr_o and re-arm capture; clear wins over a same-cycle mismatch.
REQ-024 SHALL, on the final ack, deassert cyc/stb next cycle, enter DONE for one cycle with done_o=1, then return to IDLE.
REQ-025 SHALL count clocks with stb high and no ack; on reaching TO_CYC, abort: deassert cyc/stb, set timeout_o, go DONE (done_o pulses).
REQ-026 SHALL reset the timeout counter on every ack.
REQ-027 SHALL clear timeout_o only on reset or err_clr_i.
REQ-028 SHALL drive busy_o=1 in BURST and DONE.
REQ-029 SHALL ignore an ack outside BURST.
REQ-030 SHALL leave the FSM unaffected if init_s falls mid-burst; the burst completes.

Reset
REQ-031 SHALL, on wb_rst_i asserted (asynchronously, including mid-burst), immediately force: wb_cyc_o=wb_stb_o=wb_we_o=0, wb_addr_o=0, wb_dat_o=0, wb_sel_o=0, wb_cti_o=0, cmd_ready_o=0, busy_o=0, done_o=0, timeout_o=0, err_cnt_o=0, first_err_addr_o=0, sync flops=0, FSM=WAIT_INIT.
REQ-032 SHALL resume from WAIT_INIT after reset release; an aborted burst is not replayed.

Verification
REQ-033 SHALL cover: init held low 50 cycles with cmd_valid_i=1 -> cmd_ready_o=0 throughout; init rises -> accept 3 cycles later (2 sync + IDLE).
REQ-034 SHALL cover: write, addr 0x100, len 3, seed 0xA000_0000, ack every cycle -> addresses 0x100/104/108/10C, data A0000000..A0000003, cti 010,010,010,111, done_o one pulse.
REQ-035 SHALL cover: read, same params, beat 2 returns 0xDEADBEEF -> err_cnt_o=1, first_err_addr_o=0x108; second bad read at 0x200 -> err_cnt_o=2, first_err_addr_o unchanged.
REQ-036 SHALL cover: len 0 read, ack never returned -> cyc drops after 1024 stb cycles, timeout_o=1, done_o pulse; err_clr_i -> timeout_o=0.
REQ-037 SHALL cover: wb_rst_i asserted on beat 1 of a write burst -> cyc/stb low in the same cycle, all outputs at reset values, FSM WAIT_INIT.
REQ-038 SHALL cover: addr 0x3FFFFFC, len 1 write -> second beat address 0x0000000.
